// File: rtl/pattern_scan_fsm_if.sv
// pattern_scan_fsm_if: switch/load/pause inputs and display/status outputs of pattern_scan_fsm.
//   switches      word to scan, sampled on load
//   switch_pause  0 = pause, 1 = run
//   load          start/restart request
//   seg_display   active-low {g,f,e,d,c,b,a} hex digit of the match count
//   led_state     one-hot state (IDLE=0001, SCAN=0010, PAUSE=0100, DONE=1000)
//   match         one-cycle pulse per detected match
//   done          high while the scan is finished
// master drives the inputs (stimulus side); slave is the scanner itself.
interface pattern_scan_fsm_if #(
  parameter int unsigned N = 10
);
  logic [N-1:0] switches;
  logic         switch_pause;
  logic         load;
  logic [6:0]   seg_display;
  logic [3:0]   led_state;
  logic         match;
  logic         done;

  modport master (
    output switches, switch_pause, load,
    input  seg_display, led_state, match, done
  );

  modport slave (
    input  switches, switch_pause, load,
    output seg_display, led_state, match, done
  );
endinterface

// File: rtl/pattern_scan_fsm.sv
// pattern_scan_fsm: Moore scanner that walks a captured N-bit word LSB first, one bit per
// TICK_DIV clocks, and counts occurrences of a PLEN-bit pattern (PATTERN bit PLEN-1 is the
// oldest bit). OVERLAP=0 clears the match history after each hit.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  pattern_scan_fsm_if.slave (switches, switch_pause, load in;
//        seg_display, led_state, match, done out)
module pattern_scan_fsm #(
  parameter int unsigned     N        = 10,
  parameter int unsigned     PLEN     = 3,
  parameter logic [PLEN-1:0] PATTERN  = 3'b101,
  parameter int unsigned     TICK_DIV = 4,
  parameter bit              OVERLAP  = 1'b1
) (
  input logic                clk,
  input logic                rst,
  pattern_scan_fsm_if.slave  bus
);

  localparam int unsigned IW = $clog2(N + 1);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned VW = $clog2(PLEN + 1);

  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(N - 1);
  localparam logic [VW-1:0] ValidFull = VW'(PLEN);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StScan  = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    buffer_q, buffer_d;
  logic [IW-1:0]   index_q, index_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [PLEN-1:0] hist_q, hist_d;
  logic [VW-1:0]   valid_q, valid_d;
  logic [3:0]      count_q, count_d;
  logic            match_q, match_d;

  // Candidate results of a step, computed unconditionally and used only on a step edge.
  logic [N-1:0]    buffer_shift;
  logic            step_bit;
  logic [PLEN:0]   hist_ext;
  logic [PLEN-1:0] hist_step;
  logic [VW-1:0]   valid_step;
  logic            hit;

  assign buffer_shift = buffer_q >> index_q;
  assign step_bit     = buffer_shift[0];
  // Shift in via a one-bit-wider vector so PLEN=1 needs no special case.
  assign hist_ext     = {hist_q, step_bit};
  assign hist_step    = hist_ext[PLEN-1:0];
  assign valid_step   = (valid_q == ValidFull) ? ValidFull : valid_q + 1'b1;
  assign hit          = (hist_step == PATTERN) && (valid_step == ValidFull);

  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    index_d  = index_q;
    presc_d  = presc_q;
    hist_d   = hist_q;
    valid_d  = valid_q;
    count_d  = count_q;
    match_d  = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (bus.load) begin
          buffer_d = bus.switches;
          index_d  = '0;
          presc_d  = '0;
          hist_d   = '0;
          valid_d  = '0;
          count_d  = '0;
          state_d  = StScan;
        end
      end
      StScan: begin
        // Pause wins over a coincident step; the prescaler holds its value.
        if (!bus.switch_pause) begin
          state_d = StPause;
        end else if (presc_q == PrescLast) begin
          presc_d = '0;
          hist_d  = hist_step;
          valid_d = (hit && !OVERLAP) ? '0 : valid_step;
          index_d = index_q + 1'b1;
          if (hit) begin
            match_d = 1'b1;
            count_d = (count_q == 4'hf) ? 4'hf : count_q + 4'd1;
          end
          if (index_q == IdxLast) begin
            state_d = StDone;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StPause: begin
        if (bus.switch_pause) begin
          state_d = StScan;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      buffer_q <= '0;
      index_q  <= '0;
      presc_q  <= '0;
      hist_q   <= '0;
      valid_q  <= '0;
      count_q  <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      index_q  <= index_d;
      presc_q  <= presc_d;
      hist_q   <= hist_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      match_q  <= match_d;
    end
  end

  always_comb begin
    bus.led_state = 4'b0001;
    case (state_q)
      StIdle:  bus.led_state = 4'b0001;
      StScan:  bus.led_state = 4'b0010;
      StPause: bus.led_state = 4'b0100;
      StDone:  bus.led_state = 4'b1000;
      default: bus.led_state = 4'b0001;
    endcase
  end

  always_comb begin
    bus.seg_display = 7'b1000000;
    case (count_q)
      4'h0: bus.seg_display = 7'b1000000;
      4'h1: bus.seg_display = 7'b1111001;
      4'h2: bus.seg_display = 7'b0100100;
      4'h3: bus.seg_display = 7'b0110000;
      4'h4: bus.seg_display = 7'b0011001;
      4'h5: bus.seg_display = 7'b0010010;
      4'h6: bus.seg_display = 7'b0000010;
      4'h7: bus.seg_display = 7'b1111000;
      4'h8: bus.seg_display = 7'b0000000;
      4'h9: bus.seg_display = 7'b0010000;
      4'ha: bus.seg_display = 7'b0001000;
      4'hb: bus.seg_display = 7'b0000011;
      4'hc: bus.seg_display = 7'b1000110;
      4'hd: bus.seg_display = 7'b0100001;
      4'he: bus.seg_display = 7'b0000110;
      4'hf: bus.seg_display = 7'b0001110;
      default: bus.seg_display = 7'b1000000;
    endcase
  end

  assign bus.match = match_q;
  assign bus.done  = (state_q == StDone);

endmodule
